unidad_control_pipeline: RTL and testbench

Sequencer for the 5-stage MIPS pipeline. It gates stage-register enables according to debug commands (run, single step, stop) and the halt instruction. It merges the load-use stall from the hazard detection unit and the branch-taken flush from ID into per-register write, flush and bubble controls. After a halt it drains the pipeline for a fixed number of cycles and reports halted status plus an executed-cycle count to the debug unit.

---
 rtl/unidad_control_pipeline_pkg.sv | 26 ++
 rtl/unidad_control_pipeline_contador.sv | 39 +++
 rtl/unidad_control_pipeline.sv | 148 ++++++++++++++
 tb/tb_unidad_control_pipeline.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_control_pipeline_pkg.sv
// Shared definitions for the pipeline sequencer.
// The debug unit imports this package too, so that it decodes o_state with
// exactly the same encoding the sequencer uses.
package unidad_control_pipeline_pkg;

    // Sequencer states. The encoding is visible on o_state, so it must stay fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_DRAIN = 2'b11
    } estado_e;

    // Default number of cycles the pipeline keeps moving after halt leaves ID.
    // These cycles carry the halt instruction through EX, MEM and WB.
    localparam int DRAIN_CYCLES_DEF = 3;

    // Default width of the executed-cycle counter.
    localparam int COUNT_W_DEF = 32;

    // True in the states where the pipeline advances one instruction per cycle.
    function automatic logic es_avance(estado_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/unidad_control_pipeline_contador.sv
// Saturating up-counter with an enable and an asynchronous active-low clear.
// It counts the cycles in which the pipeline actually advanced. When it
// reaches all-ones it holds that value, so a long run never reads as a
// small count.
module contador_saturado #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         saturado;

    assign saturado = (count_q == {W{1'b1}});

    // Next value: add one only when enabled and not already at the top.
    always_comb begin
        count_d = count_q;
        if (i_en && !saturado) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously together with the sequencer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/unidad_control_pipeline.sv
// Sequencer for the 5-stage MIPS pipeline.
// It gates the PC and stage-register enables from the debug commands,
// merges the load-use stall and the branch flush into per-register
// controls, drains the pipeline after a halt instruction, and reports the
// halted flag plus the number of cycles executed.
module unidad_control_pipeline
    import unidad_control_pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int COUNT_W      = COUNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_stop,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic               i_halt_ID,
    output logic               o_pc_we,
    output logic               o_if_id_we,
    output logic               o_if_id_flush,
    output logic               o_id_ex_bubble,
    output logic               o_pipe_en,
    output logic [1:0]         o_state,
    output logic               o_halted,
    output logic [COUNT_W-1:0] o_cycle_count
);

    // The drain counter runs from DRAIN_CYCLES-1 down to zero, so it needs
    // one bit more than clog2 to hold that value for every legal setting.
    // DRAIN_CYCLES must be at least 1.
    localparam int             DW         = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    estado_e        state_q;
    estado_e        state_d;
    logic [DW-1:0]  drainCnt_q;
    logic [DW-1:0]  drainCnt_d;
    logic           halted_q;
    logic           halted_d;

    // A halt only takes effect when ID is not stalled; a stalled halt is
    // retried on the following cycle like any other stalled instruction.
    logic haltGo;
    assign haltGo = i_halt_ID && !i_stall;

    // Next state: debug commands in IDLE, stop/halt in RUN, one-shot STEP,
    // and the fixed-length drain that ends by setting the sticky halted flag.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        halted_d   = halted_q;
        unique case (state_q)
            ST_IDLE: begin
                // Once halted, only a reset brings the pipeline back.
                // Stop beats run, run beats step.
                if (!halted_q && !i_stop) begin
                    if (i_run) begin
                        state_d = ST_RUN;
                    end else if (i_step) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (haltGo) begin
                    state_d    = ST_DRAIN;
                    drainCnt_d = DRAIN_LOAD;
                end else if (i_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (haltGo) begin
                    state_d    = ST_DRAIN;
                    drainCnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else begin
                    drainCnt_d = drainCnt_q - DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, drain counter and halted flag; reset returns straight to IDLE
    // even in the middle of a drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            drainCnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            halted_q   <= halted_d;
        end
    end

    // Output decode: combinational from the state and the ID-stage inputs so
    // the controls act in the same cycle the hazard or halt is seen.
    always_comb begin
        o_pc_we        = 1'b0;
        o_if_id_we     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pipe_en      = 1'b0;
        if (es_avance(state_q)) begin
            o_pipe_en = 1'b1;
            if (i_stall) begin
                // Hold PC and IF/ID, insert a bubble behind the load.
                o_id_ex_bubble = 1'b1;
            end else begin
                // The halt itself moves on into ID/EX; nothing after it
                // may be fetched, so PC freezes and IF/ID gets a NOP.
                o_if_id_we    = 1'b1;
                o_pc_we       = !i_halt_ID;
                o_if_id_flush = i_branch_taken || i_halt_ID;
            end
        end else if (state_q == ST_DRAIN) begin
            o_pipe_en      = 1'b1;
            o_id_ex_bubble = 1'b1;
        end
    end

    assign o_state  = state_q;
    assign o_halted = halted_q;

    contador_saturado #(
        .W (COUNT_W)
    ) u_contador (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_pipe_en),
        .o_count (o_cycle_count)
    );

endmodule

// File: tb/tb_unidad_control_pipeline.sv
// Self-checking bench for the pipeline sequencer.
// A second instance with a 4-bit counter shares all inputs and is used to
// observe counter saturation.
module tb_unidad_control_pipeline;

    logic clk = 1'b0;
    logic rstN;
    logic run, step, stop, stall, branch, halt;

    logic       pcWe, ifIdWe, ifIdFlush, idExBubble, pipeEn, halted;
    logic [1:0] state;
    logic [31:0] cycleCount;

    logic       pcWe4, ifIdWe4, ifIdFlush4, idExBubble4, pipeEn4, halted4;
    logic [1:0] state4;
    logic [3:0] cycleCount4;

    logic [6:0] actVec;

    typedef struct {
        string      name;
        logic [6:0] vec;
    } expT;

    typedef struct {
        logic       step;
        logic       stall;
        logic       branch;
        logic       halt;
        logic [6:0] exp;
        string      name;
    } vecT;

    expT expQ[$];
    vecT tbl[7];
    int  checks = 0;
    int  errors = 0;

    logic [6:0] idle0, runNorm, runBranch, runStall, runHalt, stepNorm, drainVec;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    assign actVec = {state, pcWe, ifIdWe, ifIdFlush, idExBubble, pipeEn};

    unidad_control_pipeline dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_run          (run),
        .i_step         (step),
        .i_stop         (stop),
        .i_stall        (stall),
        .i_branch_taken (branch),
        .i_halt_ID      (halt),
        .o_pc_we        (pcWe),
        .o_if_id_we     (ifIdWe),
        .o_if_id_flush  (ifIdFlush),
        .o_id_ex_bubble (idExBubble),
        .o_pipe_en      (pipeEn),
        .o_state        (state),
        .o_halted       (halted),
        .o_cycle_count  (cycleCount)
    );

    unidad_control_pipeline #(
        .COUNT_W (4)
    ) dut4 (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_run          (run),
        .i_step         (step),
        .i_stop         (stop),
        .i_stall        (stall),
        .i_branch_taken (branch),
        .i_halt_ID      (halt),
        .o_pc_we        (pcWe4),
        .o_if_id_we     (ifIdWe4),
        .o_if_id_flush  (ifIdFlush4),
        .o_id_ex_bubble (idExBubble4),
        .o_pipe_en      (pipeEn4),
        .o_state        (state4),
        .o_halted       (halted4),
        .o_cycle_count  (cycleCount4)
    );

    function automatic logic [6:0] ex(input logic [1:0] s, input logic pc, input logic ifid,
                                      input logic fl, input logic bub, input logic pe);
        return {s, pc, ifid, fl, bub, pe};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic checkOutput();
        expT e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got output %b expected nothing queued", actVec);
        end else begin
            e = expQ.pop_front();
            if (actVec !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got {state,pc,ifid,flush,bubble,pipe}=%b expected %b",
                         e.name, actVec, e.vec);
            end
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, queue the
    // expectation, compare on the falling edge, then move past the next edge.
    task automatic applyStimulus(input logic r, input logic s, input logic sp, input logic st,
                                 input logic br, input logic h, input logic [6:0] e,
                                 input string name);
        run    = r;
        step   = s;
        stop   = sp;
        stall  = st;
        branch = br;
        halt   = h;
        expQ.push_back('{name: name, vec: e});
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN   = 1'b0;
        run    = 1'b0;
        step   = 1'b0;
        stop   = 1'b0;
        stall  = 1'b0;
        branch = 1'b0;
        halt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        idle0     = ex(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runNorm   = ex(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        runBranch = ex(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        runStall  = ex(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        runHalt   = ex(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        stepNorm  = ex(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drainVec  = ex(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        tbl[0] = '{step: 1'b0, stall: 1'b0, branch: 1'b0, halt: 1'b0, exp: runNorm,   name: "run_normal"};
        tbl[1] = '{step: 1'b0, stall: 1'b0, branch: 1'b1, halt: 1'b0, exp: runBranch, name: "run_branch"};
        tbl[2] = '{step: 1'b0, stall: 1'b1, branch: 1'b0, halt: 1'b0, exp: runStall,  name: "run_stall"};
        tbl[3] = '{step: 1'b0, stall: 1'b1, branch: 1'b1, halt: 1'b0, exp: runStall,  name: "stall_over_branch"};
        tbl[4] = '{step: 1'b0, stall: 1'b1, branch: 1'b1, halt: 1'b1, exp: runStall,  name: "stall_over_halt"};
        tbl[5] = '{step: 1'b0, stall: 1'b0, branch: 1'b1, halt: 1'b0, exp: runBranch, name: "branch_after_stall"};
        tbl[6] = '{step: 1'b1, stall: 1'b0, branch: 1'b0, halt: 1'b0, exp: runNorm,   name: "step_ignored_in_run"};

        // Reset and idle with no command.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, idle0, "idle_after_reset");
        checkVal("idle_count", cycleCount, 0);
        checkVal("idle_halted", {31'b0, halted}, 0);

        // Single steps, four cycles apart.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, idle0, "step_request");
            applyStimulus(0, 0, 0, 0, 0, 0, stepNorm, "step_cycle");
            applyStimulus(0, 0, 0, 0, 0, 0, idle0, "step_back_idle");
            applyStimulus(0, 0, 0, 0, 0, 0, idle0, "step_gap");
        end
        checkVal("step_count", cycleCount, 3);

        // Decode table in RUN.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_request");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, tbl[i].step, 0, tbl[i].stall, tbl[i].branch, tbl[i].halt,
                          tbl[i].exp, tbl[i].name);
        end
        checkVal("table_count", cycleCount, 7);

        // Run ten cycles, stop, then stop beats run in IDLE.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_request");
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0, runNorm, "run_cycle");
        applyStimulus(0, 0, 1, 0, 0, 0, runNorm, "stop_cycle_advances");
        applyStimulus(0, 0, 0, 0, 0, 0, idle0, "idle_after_stop");
        checkVal("stop_count", cycleCount, 11);
        checkVal("stop_count_w4", {28'b0, cycleCount4}, 11);
        applyStimulus(1, 0, 1, 0, 0, 0, idle0, "run_with_stop");
        applyStimulus(0, 0, 0, 0, 0, 0, idle0, "stop_beats_run");
        checkVal("stop_count_hold", cycleCount, 11);

        // Saturation of the 4-bit counter.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_request");
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, runNorm, "run_cycle");
        checkVal("sat_count_w4", {28'b0, cycleCount4}, 15);
        checkVal("sat_count_w32", cycleCount, 20);

        // Halt and drain; afterwards commands are ignored.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_request");
        applyStimulus(1, 0, 0, 0, 0, 0, runNorm, "run_cycle");
        applyStimulus(1, 0, 0, 0, 0, 0, runNorm, "run_cycle");
        applyStimulus(1, 0, 0, 0, 0, 1, runHalt, "halt_in_id");
        applyStimulus(1, 0, 0, 0, 0, 0, drainVec, "drain_1");
        applyStimulus(1, 0, 1, 1, 1, 0, drainVec, "drain_2_ignores");
        applyStimulus(1, 1, 0, 0, 0, 0, drainVec, "drain_3");
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "idle_after_drain");
        checkVal("halted_set", {31'b0, halted}, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_ignored_halted");
        applyStimulus(0, 1, 0, 0, 0, 0, idle0, "step_ignored_halted");
        applyStimulus(0, 0, 0, 0, 0, 0, idle0, "still_idle_halted");
        checkVal("halt_count", cycleCount, 6);

        // Asynchronous reset mid-cycle while halted.
        #1 rstN = 1'b0;
        #1;
        checkVal("async_halted", {31'b0, halted}, 0);
        checkVal("async_count", cycleCount, 0);
        checkVal("async_state", {30'b0, state}, 0);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Asynchronous reset in the middle of a drain.
        applyStimulus(1, 0, 0, 0, 0, 0, idle0, "run_request");
        applyStimulus(1, 0, 0, 0, 0, 0, runNorm, "run_cycle");
        applyStimulus(1, 0, 0, 0, 0, 1, runHalt, "halt_in_id");
        applyStimulus(1, 0, 0, 0, 0, 0, drainVec, "drain_1");
        checkVal("mid_drain_state_before", {30'b0, state}, 3);
        #1 rstN = 1'b0;
        #1;
        checkVal("mid_drain_state", {30'b0, state}, 0);
        checkVal("mid_drain_pipe_en", {31'b0, pipeEn}, 0);
        checkVal("mid_drain_count", cycleCount, 0);
        checkVal("mid_drain_halted", {31'b0, halted}, 0);
        @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, idle0, "idle_after_drain_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
